// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// State encoding, special digit codes, and a decimal power helper for range limits.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_DASH = 4'hF;
  localparam logic [3:0] DIGIT_NEG  = 4'hA;

  // Evaluated at elaboration to size the display range limit.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD digit correction step for the shift-and-add-3 converter.
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Iterative binary-to-BCD converter: one shift per clock, BIN_WIDTH shifts per conversion.
// Define BIN_TO_BCD_SIGNED_EN for two's-complement input with a sign digit in the top position.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | add-3 correction then shift, BIN_WIDTH times
// DONE  | publish result, pulse done, return to IDLE
module bin_to_bcd_serial
  import bcd_display_pkg::*;
#(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   binary,
  output logic [4*DIGITS-1:0]    bcd,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int SR_W  = 4*DIGITS + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

`ifdef BIN_TO_BCD_SIGNED_EN
  localparam logic [63:0] LIMIT   = pow10(DIGITS - 1) - 64'd1;
  localparam logic [63:0] MAX_MAG = 64'd1 << (BIN_WIDTH - 1);
`else
  localparam logic [63:0] LIMIT   = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MAX_MAG = (64'd1 << BIN_WIDTH) - 64'd1;
`endif
  // When the input width cannot reach the limit, the range flag folds to 0.
  localparam bit CAN_OVF = (MAX_MAG > LIMIT);

  state_t               state;
  logic [SR_W-1:0]      sr;
  logic [CNT_W-1:0]     cnt;
  logic                 rng;
  logic [BIN_WIDTH-1:0] mag;
  logic                 range_in;
  logic [4*DIGITS-1:0]  adj;
  logic [SR_W-1:0]      sr_adj;
  logic [4*DIGITS-1:0]  result;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic neg;
  logic neg_in;

  assign neg_in   = binary[BIN_WIDTH-1];
  assign mag      = neg_in ? (~binary + BIN_WIDTH'(1)) : binary;
  assign range_in = CAN_OVF && ((64'(mag) > LIMIT) ||
                    (binary == {1'b1, {(BIN_WIDTH-1){1'b0}}}));

  always_comb begin
    result = sr[SR_W-1 -: 4*DIGITS];
    result[4*DIGITS-1 -: 4] = neg ? DIGIT_NEG : 4'h0;
  end
`else
  assign mag      = binary;
  assign range_in = CAN_OVF && (64'(binary) > LIMIT);
  assign result   = sr[SR_W-1 -: 4*DIGITS];
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit    (sr[BIN_WIDTH + 4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

  assign sr_adj = {adj, sr[BIN_WIDTH-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      rng      <= 1'b0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{(4*DIGITS){1'b0}}, mag};
            cnt   <= '0;
            rng   <= range_in;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
            neg   <= neg_in;
`endif
          end
        end
        SHIFT: begin
          sr  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          bcd      <= rng ? {DIGITS{DIGIT_DASH}} : result;
          overflow <= rng;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial against a decimal-arithmetic reference model.
// Follows BIN_TO_BCD_SIGNED_EN the same way the design does.
module tb_bin_to_bcd_serial;

  localparam int BW = 20;
  localparam int DG = 6;

  logic              clock;
  logic              reset;
  logic              start;
  logic [BW-1:0]     binary;
  logic [4*DG-1:0]   bcd;
  logic              busy;
  logic              done;
  logic              overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4*DG:0] last_exp;

  bin_to_bcd_serial #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .binary   (binary),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Returns {overflow, bcd} from plain decimal arithmetic.
  function automatic logic [4*DG:0] ref_conv(input logic [BW-1:0] v);
    longint m;
    longint lim;
    bit neg;
    int nd;
    logic [4*DG-1:0] r;
`ifdef BIN_TO_BCD_SIGNED_EN
    neg = v[BW-1];
    m   = neg ? (longint'(1) << BW) - longint'(v) : longint'(v);
    nd  = DG - 1;
`else
    neg = 1'b0;
    m   = longint'(v);
    nd  = DG;
`endif
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (m > lim - 1) return {1'b1, {DG{4'hF}}};
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    if (neg) r[4*DG-1 -: 4] = 4'hA;
    return {1'b0, r};
  endfunction

  task automatic run_conv(input logic [BW-1:0] val, input string tag);
    int cyc;
    logic busy20;
    @(negedge clock);
    start  = 1'b1;
    binary = val;
    @(posedge clock);
    #1;
    start = 1'b0;
    binary = BW'($urandom);
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    cyc = 0;
    busy20 = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 20) busy20 = busy;
    end
    last_exp = ref_conv(val);
    chk({tag, "_latency"}, 64'(cyc), 64'(BW + 1));
    chk({tag, "_busy_late"}, 64'(busy20), 64'd1);
    chk({tag, "_bcd"}, 64'(bcd), 64'(last_exp[4*DG-1:0]));
    chk({tag, "_ovf"}, 64'(overflow), 64'(last_exp[4*DG]));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [BW-1:0] dir_vals[$];
    logic [4*DG:0] e1, e2;
    int n_done, d1, d2;
    logic [4*DG-1:0] bcd1;
    logic held_ok;

    reset  = 1'b0;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

`ifdef BIN_TO_BCD_SIGNED_EN
    dir_vals = '{20'hFFFD6, 20'(-100000), 20'd99999, 20'd0, 20'h80000, 20'h7FFFF, 20'(-99999)};
`else
    dir_vals = '{20'd123456, 20'd0, 20'd999999, 20'd1000000, 20'd1048575, 20'd9, 20'd10};
`endif
    foreach (dir_vals[i]) run_conv(dir_vals[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) run_conv(BW'($urandom_range(0, 999999)), $sformatf("rnd%0d", i));
      else            run_conv(BW'($urandom), $sformatf("rnd%0d", i));
    end

    // Output hold with random binary and no start.
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      binary = BW'($urandom);
      @(posedge clock);
      #1;
      if (bcd !== last_exp[4*DG-1:0] || overflow !== last_exp[4*DG] || done !== 1'b0)
        held_ok = 1'b0;
    end
    chk("hold_bcd", 64'(bcd), 64'(last_exp[4*DG-1:0]));
    chk("hold_ovf", 64'(overflow), 64'(last_exp[4*DG]));
    chk("hold_all_cycles", 64'(held_ok), 64'd1);

    // Start while busy is ignored; start right after done is accepted.
    e1 = ref_conv(20'd42);
    e2 = ref_conv(20'd31337);
    n_done = 0; d1 = -1; d2 = -1; bcd1 = '0;
    for (int cyc = 0; cyc <= 50; cyc++) begin
      @(negedge clock);
      start  = (cyc == 0 || cyc == 5 || cyc == 22);
      binary = (cyc == 0) ? 20'd42 : (cyc == 5) ? 20'd777 : (cyc == 22) ? 20'd31337 : BW'($urandom);
      @(posedge clock);
      #1;
      if (done) begin
        n_done++;
        if (d1 < 0) begin d1 = cyc; bcd1 = bcd; end
        else if (d2 < 0) d2 = cyc;
      end
    end
    start = 1'b0;
    chk("bb_first_done", 64'(d1), 64'd21);
    chk("bb_first_bcd", 64'(bcd1), 64'(e1[4*DG-1:0]));
    chk("bb_second_done", 64'(d2), 64'd43);
    chk("bb_second_bcd", 64'(bcd), 64'(e2[4*DG-1:0]));
    chk("bb_done_count", 64'(n_done), 64'd2);

    // Asynchronous reset during SHIFT.
    @(negedge clock);
    start  = 1'b1;
    binary = 20'd888888;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_bcd", 64'(bcd), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    run_conv(20'd654321, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
